// File: rtl/avalon_st_downsizer_pkg.sv
// Shared widths and the held-beat record for the 32-to-8 Avalon-ST downsizer.
package avalon_st_downsizer_pkg;

    localparam int SYMBOL_W   = 8;
    localparam int IN_SYMBOLS = 4;
    localparam int DATA_W     = SYMBOL_W * IN_SYMBOLS;
    localparam int CHANNEL_W  = 2;
    localparam int ERROR_W    = 6;
    localparam int EMPTY_W    = 2;
    localparam int IDX_W      = 2;
    localparam int PKT_CNT_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [CHANNEL_W-1:0] channel;
        logic [ERROR_W-1:0]   error;
        logic                 sop;
        logic                 eop;
        logic [IDX_W-1:0]     last_idx;
    } st_beat_t;

    // Index of the final valid symbol; empty only counts on an EOP beat.
    function automatic logic [IDX_W-1:0] last_symbol_idx(input logic eop,
                                                         input logic [EMPTY_W-1:0] empty);
        logic [IDX_W-1:0] full_idx;
        full_idx = IDX_W'(IN_SYMBOLS - 1);
        return eop ? (full_idx - empty) : full_idx;
    endfunction

endpackage

// File: rtl/avalon_st_downsizer_32to8.sv
// Splits 32-bit 4-symbol Avalon-ST beats into 8-bit beats, first symbol at [31:24].
// Optional AVALON_ST_DOWNSIZER_PKT_CNT_EN adds a 16-bit count of emitted packets.
module avalon_st_downsizer_32to8
    import avalon_st_downsizer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [CHANNEL_W-1:0] in_channel,
    input  logic [ERROR_W-1:0]   in_error,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    input  logic [EMPTY_W-1:0]   in_empty,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [SYMBOL_W-1:0]  out_data,
    output logic [CHANNEL_W-1:0] out_channel,
    output logic [ERROR_W-1:0]   out_error,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket
`ifdef AVALON_ST_DOWNSIZER_PKT_CNT_EN
    ,
    output logic [PKT_CNT_W-1:0] out_pkt_count
`endif
);

    st_beat_t            hold_reg;
    logic                hold_valid_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                at_last;
    logic                in_accept;
    logic                out_xfer;
    logic [SYMBOL_W-1:0] symbols [IN_SYMBOLS];

    assign at_last   = (idx_reg == hold_reg.last_idx);
    // The next beat loads in the same cycle the last held symbol leaves.
    assign in_ready  = reset_n && (!hold_valid_reg || (out_ready && at_last));
    assign in_accept = in_valid && in_ready;
    assign out_xfer  = hold_valid_reg && out_ready;

    generate
        for (genvar gi = 0; gi < IN_SYMBOLS; gi++) begin : g_sym
            assign symbols[gi] = hold_reg.data[DATA_W-1-gi*SYMBOL_W -: SYMBOL_W];
        end
    endgenerate

    assign out_valid         = hold_valid_reg;
    assign out_data          = symbols[idx_reg];
    assign out_channel       = hold_reg.channel;
    assign out_error         = hold_reg.error;
    assign out_startofpacket = hold_reg.sop && (idx_reg == '0);
    assign out_endofpacket   = hold_reg.eop && at_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            idx_reg        <= '0;
        end else begin
            if (in_accept) begin
                hold_reg.data     <= in_data;
                hold_reg.channel  <= in_channel;
                hold_reg.error    <= in_error;
                hold_reg.sop      <= in_startofpacket;
                hold_reg.eop      <= in_endofpacket;
                hold_reg.last_idx <= last_symbol_idx(in_endofpacket, in_empty);
            end
            if (out_xfer) begin
                if (at_last) begin
                    idx_reg        <= '0;
                    hold_valid_reg <= in_accept;
                end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                end
            end else if (!hold_valid_reg) begin
                hold_valid_reg <= in_accept;
            end
        end
    end

`ifdef AVALON_ST_DOWNSIZER_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] pkt_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count_reg <= '0;
        end else if (out_xfer && out_endofpacket) begin
            pkt_count_reg <= pkt_count_reg + PKT_CNT_W'(1);
        end
    end

    assign out_pkt_count = pkt_count_reg;
`endif

endmodule

// File: tb/tb_avalon_st_downsizer_32to8.sv
// Directed bench for avalon_st_downsizer_32to8: symbol-queue model checked every cycle
// plus literal sequence expectations for each scenario.
module tb_avalon_st_downsizer_32to8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_ready;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [1:0]  in_channel = '0;
    logic [5:0]  in_error = '0;
    logic        in_startofpacket = 1'b0;
    logic        in_endofpacket = 1'b0;
    logic [1:0]  in_empty = '0;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_channel;
    logic [5:0]  out_error;
    logic        out_startofpacket;
    logic        out_endofpacket;
`ifdef AVALON_ST_DOWNSIZER_PKT_CNT_EN
    logic [15:0] out_pkt_count;
`endif

    avalon_st_downsizer_32to8 dut (
        .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
        .in_data(in_data), .in_channel(in_channel), .in_error(in_error),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_empty(in_empty), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_channel(out_channel), .out_error(out_error),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket)
`ifdef AVALON_ST_DOWNSIZER_PKT_CNT_EN
        , .out_pkt_count(out_pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ready_mode = 0;   // 0: out_ready held high, 1: toggles every cycle

    always @(posedge clk) cyc++;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) out_ready = ~out_ready;
            else out_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the symbols still owed by the single held beat.
    typedef struct {
        logic [7:0] d;
        logic [1:0] ch;
        logic [5:0] err;
        logic       sop;
        logic       eop;
    } sym_t;

    sym_t q[$];
    int   model_cnt = 0;
    bit   pend_xfer = 0;
    bit   pend_acc = 0;
    logic [31:0] pend_d;
    logic [1:0]  pend_ch, pend_em;
    logic [5:0]  pend_err;
    logic        pend_sop, pend_eop;

    logic [7:0] obs_d[$];
    logic [1:0] obs_ch[$];
    logic [5:0] obs_err[$];
    logic       obs_sop[$];
    logic       obs_eop[$];
    int         obs_cyc[$];

    task automatic obs_clear();
        obs_d.delete(); obs_ch.delete(); obs_err.delete();
        obs_sop.delete(); obs_eop.delete(); obs_cyc.delete();
    endtask

    // Compare at negedge, advance model at posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q.delete();
                model_cnt = 0;
                pend_xfer = 0;
                pend_acc = 0;
                chk("rst_out_valid", {31'b0, out_valid}, 0);
                chk("rst_in_ready", {31'b0, in_ready}, 0);
                chk("rst_out_sop_eop", {30'b0, out_startofpacket, out_endofpacket}, 0);
                chk("rst_out_fields", {16'b0, out_data, out_channel, out_error}, 0);
            end else begin
                chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
                if (q.size() > 0) begin
                    chk("out_data", {24'b0, out_data}, {24'b0, q[0].d});
                    chk("out_channel", {30'b0, out_channel}, {30'b0, q[0].ch});
                    chk("out_error", {26'b0, out_error}, {26'b0, q[0].err});
                    chk("out_sop", {31'b0, out_startofpacket}, {31'b0, q[0].sop});
                    chk("out_eop", {31'b0, out_endofpacket}, {31'b0, q[0].eop});
                end
                chk("in_ready", {31'b0, in_ready},
                    {31'b0, (q.size() == 0) || (out_ready && q.size() == 1)});
`ifdef AVALON_ST_DOWNSIZER_PKT_CNT_EN
                chk("pkt_count", {16'b0, out_pkt_count}, model_cnt & 32'hFFFF);
`endif
                pend_xfer = (q.size() > 0) && out_ready;
                pend_acc  = in_valid && ((q.size() == 0) || (out_ready && q.size() == 1));
                pend_d = in_data; pend_ch = in_channel; pend_err = in_error;
                pend_sop = in_startofpacket; pend_eop = in_endofpacket; pend_em = in_empty;
                if (out_valid && out_ready) begin
                    obs_d.push_back(out_data); obs_ch.push_back(out_channel);
                    obs_err.push_back(out_error); obs_sop.push_back(out_startofpacket);
                    obs_eop.push_back(out_endofpacket); obs_cyc.push_back(cyc);
                end
            end
            @(posedge clk);
            if (reset_n) begin
                if (pend_xfer) begin
                    if (q[0].eop) model_cnt++;
                    void'(q.pop_front());
                end
                if (pend_acc) begin
                    int n;
                    n = pend_eop ? 4 - int'(pend_em) : 4;
                    for (int k = 0; k < n; k++) begin
                        sym_t s;
                        s.d = 8'((pend_d >> (8 * (3 - k))) & 32'hFF);
                        s.ch = pend_ch;
                        s.err = pend_err;
                        s.sop = pend_sop && (k == 0);
                        s.eop = pend_eop && (k == n - 1);
                        q.push_back(s);
                    end
                end
            end
            pend_xfer = 0;
            pend_acc = 0;
        end
    end

    // Caller is just after a posedge; returns just after the accepting posedge.
    task automatic send_beat(input logic [31:0] d, input logic [1:0] ch, input logic [5:0] er,
                             input logic s, input logic e, input logic [1:0] em);
        int  t = 0;
        bit  done = 0;
        in_valid = 1'b1; in_data = d; in_channel = ch; in_error = er;
        in_startofpacket = s; in_endofpacket = e; in_empty = em;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                acc_cyc = cyc + 1;
            end else if (++t > 200) begin
                chk("accept_timeout", 0, 1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bytes(input string name, input logic [7:0] exp_b [], input int n);
        chk({name, "_count"}, obs_d.size(), n);
        for (int i = 0; i < n && i < obs_d.size(); i++)
            chk(name, {24'b0, obs_d[i]}, {24'b0, exp_b[i]});
    endtask

    initial begin
        logic [7:0] e1 [] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [7:0] e2 [] = '{8'h11, 8'h22, 8'h55};
        logic [7:0] e3 [] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        logic [7:0] e5 [] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int t;

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        obs_clear();

        // Single-beat packet
        send_beat(32'hAABBCCDD, 2'd0, 6'd0, 1'b1, 1'b1, 2'd0);
        wait_idle();
        $display("single_beat: %0d symbols", obs_d.size());
        expect_bytes("single_beat", e1, 4);
        chk("single_sop", {31'b0, obs_sop[0]}, 1);
        chk("single_eop", {31'b0, obs_eop[3]}, 1);
        chk("single_latency", obs_cyc[0], acc_cyc);
        chk("single_span", obs_cyc[3] - obs_cyc[0], 3);

        // Empty handling followed by a single-symbol beat
        obs_clear();
        send_beat(32'h11223344, 2'd1, 6'd3, 1'b1, 1'b1, 2'd2);
        send_beat(32'h55667788, 2'd1, 6'd3, 1'b1, 1'b1, 2'd3);
        wait_idle();
        $display("empty: %0d symbols", obs_d.size());
        expect_bytes("empty", e2, 3);
        chk("empty_eop_22", {31'b0, obs_eop[1]}, 1);
        chk("empty_span", obs_cyc[2] - obs_cyc[0], 2);

        // Backpressure with toggling out_ready
        obs_clear();
        ready_mode = 1;
        send_beat(32'hA1A2A3A4, 2'd2, 6'h15, 1'b1, 1'b0, 2'd0);
        send_beat(32'hB1B2B3B4, 2'd2, 6'h15, 1'b0, 1'b1, 2'd0);
        wait_idle();
        ready_mode = 0;
        $display("backpressure: %0d symbols", obs_d.size());
        expect_bytes("backpressure", e3, 8);
        for (int i = 0; i < obs_d.size(); i++) begin
            chk("bp_channel", {30'b0, obs_ch[i]}, 2);
            chk("bp_error", {26'b0, obs_err[i]}, 32'h15);
        end
        chk("bp_eop_last", {31'b0, obs_eop[7]}, 1);

        // Back-to-back full beats; empty on a non-EOP beat is ignored
        @(posedge clk);
        #1;
        obs_clear();
        send_beat(32'h10111213, 2'd1, 6'd0, 1'b1, 1'b0, 2'd3);
        send_beat(32'h20212223, 2'd1, 6'd0, 1'b0, 1'b0, 2'd0);
        send_beat(32'h30313233, 2'd1, 6'd0, 1'b0, 1'b1, 2'd0);
        wait_idle();
        $display("back_to_back: %0d symbols", obs_d.size());
        chk("b2b_count", obs_d.size(), 12);
        chk("b2b_span", obs_cyc[11] - obs_cyc[0], 11);
        chk("b2b_sym4", {24'b0, obs_d[4]}, 32'h20);
        chk("b2b_sym11", {24'b0, obs_d[11]}, 32'h33);

        // Reset mid-beat
        obs_clear();
        send_beat(32'hDEADBEEF, 2'd3, 6'd1, 1'b1, 1'b1, 2'd0);
        in_valid = 1'b0;
        t = 0;
        while (obs_d.size() < 2 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        reset_n = 1'b0;
        #1;
        $display("reset_mid_beat: out_valid=%0b after reset", out_valid);
        chk("reset_out_valid_now", {31'b0, out_valid}, 0);
        chk("reset_in_ready_now", {31'b0, in_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_no_more_syms", obs_d.size(), 2);
        reset_n = 1'b1;
        obs_clear();
        send_beat(32'h01020304, 2'd0, 6'd0, 1'b1, 1'b1, 2'd0);
        wait_idle();
        $display("after_reset: %0d symbols", obs_d.size());
        expect_bytes("after_reset", e5, 4);

`ifdef AVALON_ST_DOWNSIZER_PKT_CNT_EN
        // Counter wrap: preload to 0xFFFE with single-symbol packets
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 65534; i++)
            send_beat(32'h77000000, 2'd0, 6'd0, 1'b1, 1'b1, 2'd3);
        wait_idle();
        chk("cnt_preload", {16'b0, out_pkt_count}, 32'hFFFE);
        send_beat(32'h78000000, 2'd0, 6'd0, 1'b1, 1'b1, 2'd3);
        wait_idle();
        chk("cnt_ffff", {16'b0, out_pkt_count}, 32'hFFFF);
        send_beat(32'h79000000, 2'd0, 6'd0, 1'b1, 1'b1, 2'd3);
        wait_idle();
        chk("cnt_wrap", {16'b0, out_pkt_count}, 32'h0);
        $display("pkt_count: wrapped to 0x%0h", out_pkt_count);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
